// File: rtl/data_cache_if.sv
// ---------------------------------------------------------------------------
// data_cache_if
// Bundles the CPU-side request/response signals and the block-memory bus of
// the data cache.
//   slave  modport : the cache's view (takes CPU requests and memory
//                    responses, drives load data, stall and memory strobes)
//   master modport : the environment's view (CPU + main memory)
// CPU side   : READ, WRITE, FUNCT3[2:0], ADDRESS[31:0], WRITEDATA[31:0] ->
//              READDATA[31:0], BUSYWAIT
// Memory side: MEM_READ, MEM_WRITE, MEM_ADDRESS[27:0], MEM_WRITEDATA[127:0] ->
//              MEM_READDATA[127:0], MEM_BUSYWAIT
// ---------------------------------------------------------------------------
interface data_cache_if;
  logic         READ;
  logic         WRITE;
  logic [2:0]   FUNCT3;
  logic [31:0]  ADDRESS;
  logic [31:0]  WRITEDATA;
  logic [31:0]  READDATA;
  logic         BUSYWAIT;
  logic         MEM_READ;
  logic         MEM_WRITE;
  logic [27:0]  MEM_ADDRESS;
  logic [127:0] MEM_WRITEDATA;
  logic [127:0] MEM_READDATA;
  logic         MEM_BUSYWAIT;

  modport slave (
    input  READ, WRITE, FUNCT3, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
    output READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
  );

  modport master (
    output READ, WRITE, FUNCT3, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
    input  READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
  );
endinterface

// File: rtl/data_cache.sv
// ---------------------------------------------------------------------------
// data_cache
// Direct-mapped, write-back, write-allocate data cache with 16-byte lines,
// sitting between the CPU memory stage and a 128-bit-block main memory.
// Hits complete with no wait states; a miss raises BUSYWAIT in the same cycle
// while the FSM writes back a dirty victim (WRITEBACK), fetches the block
// (FETCH) and installs it (ALLOCATE). Loads are sign/zero extended and stores
// sized according to the RV32 FUNCT3 encoding.
//
// Ports:
//   CLK        clock, rising edge
//   RESET      asynchronous, active-high reset
//   bus        data_cache_if.slave (CPU request/response + memory bus)
//   HIT_COUNT  [31:0] hit counter    (only with DCACHE_STATS_EN)
//   MISS_COUNT [31:0] miss counter   (only with DCACHE_STATS_EN)
//
// Configuration macro: DCACHE_STATS_EN adds the hit/miss statistics counters.
// ---------------------------------------------------------------------------
module data_cache #(
  parameter int NUM_LINES = 8
) (
  input  logic CLK,
  input  logic RESET,
  data_cache_if.slave bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] HIT_COUNT,
  output logic [31:0] MISS_COUNT
`endif
);

  localparam int INDEX_BITS = $clog2(NUM_LINES);
  localparam int TAG_BITS   = 28 - INDEX_BITS;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, ALLOCATE} state_t;

  state_t                state_q, state_d;
  logic [NUM_LINES-1:0]  valid_q, valid_d;
  logic [NUM_LINES-1:0]  dirty_q, dirty_d;
  logic [INDEX_BITS-1:0] miss_idx_q, miss_idx_d;
  logic [TAG_BITS-1:0]   miss_tag_q, miss_tag_d;

  // Tag and data storage carry no reset; the valid bits qualify them.
  logic [TAG_BITS-1:0]   tag_q  [NUM_LINES];
  logic [127:0]          data_q [NUM_LINES];

  // Single line write port shared by store hits and block fills.
  logic                  line_we;
  logic [INDEX_BITS-1:0] line_idx;
  logic [TAG_BITS-1:0]   line_tag;
  logic [127:0]          line_data;

  // Request decode
  logic                  req;
  logic [INDEX_BITS-1:0] req_idx;
  logic [TAG_BITS-1:0]   req_tag;
  logic [1:0]            word_sel;
  logic                  hit;
  logic [127:0]          cur_line;
  logic [31:0]           cur_word;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [31:0]           load_val;
  logic [31:0]           store_word;
  logic [127:0]          store_line;

  assign req      = bus.READ | bus.WRITE;
  assign req_idx  = bus.ADDRESS[3+INDEX_BITS:4];
  assign req_tag  = bus.ADDRESS[31:4+INDEX_BITS];
  assign word_sel = bus.ADDRESS[3:2];
  assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign cur_line = data_q[req_idx];
  assign cur_word = cur_line[{word_sel, 5'b00000} +: 32];
  assign ld_byte  = cur_word[{bus.ADDRESS[1:0], 3'b000} +: 8];
  assign ld_half  = cur_word[{bus.ADDRESS[1], 4'b0000} +: 16];

  // Load extension; address bits below the access size are simply ignored.
  always_comb begin
    load_val = cur_word;
    case (bus.FUNCT3)
      3'b000:  load_val = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  load_val = {{16{ld_half[15]}}, ld_half};
      3'b100:  load_val = {24'h000000, ld_byte};
      3'b101:  load_val = {16'h0000, ld_half};
      default: load_val = cur_word;
    endcase
  end

  // Store merge into the addressed word, then into the line.
  always_comb begin
    store_word = cur_word;
    case (bus.FUNCT3)
      3'b000:  store_word[{bus.ADDRESS[1:0], 3'b000} +: 8] = bus.WRITEDATA[7:0];
      3'b001:  store_word[{bus.ADDRESS[1], 4'b0000} +: 16] = bus.WRITEDATA[15:0];
      default: store_word = bus.WRITEDATA;
    endcase
    store_line = cur_line;
    store_line[{word_sel, 5'b00000} +: 32] = store_word;
  end

  // Next-state and output logic
  always_comb begin
    state_d           = state_q;
    valid_d           = valid_q;
    dirty_d           = dirty_q;
    miss_idx_d        = miss_idx_q;
    miss_tag_d        = miss_tag_q;
    line_we           = 1'b0;
    line_idx          = req_idx;
    line_tag          = req_tag;
    line_data         = store_line;
    bus.READDATA      = 32'h0;
    bus.BUSYWAIT      = 1'b0;
    bus.MEM_READ      = 1'b0;
    bus.MEM_WRITE     = 1'b0;
    bus.MEM_ADDRESS   = 28'h0;
    bus.MEM_WRITEDATA = 128'h0;

    case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            if (bus.WRITE) begin
              // WRITE wins when both strobes are high; no load data then.
              line_we          = 1'b1;
              dirty_d[req_idx] = 1'b1;
            end else begin
              bus.READDATA = load_val;
            end
          end else begin
            bus.BUSYWAIT = 1'b1;
            // Miss line/tag are latched so the memory address stays stable
            // even if the CPU drops or changes its request mid-miss.
            miss_idx_d   = req_idx;
            miss_tag_d   = req_tag;
            state_d      = (valid_q[req_idx] && dirty_q[req_idx]) ? WRITEBACK : FETCH;
          end
        end
      end

      WRITEBACK: begin
        bus.BUSYWAIT      = 1'b1;
        bus.MEM_WRITE     = 1'b1;
        bus.MEM_ADDRESS   = {tag_q[miss_idx_q], miss_idx_q};
        bus.MEM_WRITEDATA = data_q[miss_idx_q];
        if (!bus.MEM_BUSYWAIT) begin
          state_d = FETCH;
        end
      end

      FETCH: begin
        bus.BUSYWAIT    = 1'b1;
        bus.MEM_READ    = 1'b1;
        bus.MEM_ADDRESS = {miss_tag_q, miss_idx_q};
        if (!bus.MEM_BUSYWAIT) begin
          // The block is captured on the completion edge, the only point at
          // which memory guarantees MEM_READDATA. The line stays invalid
          // until ALLOCATE marks it valid and clean.
          line_we             = 1'b1;
          line_idx            = miss_idx_q;
          line_tag            = miss_tag_q;
          line_data           = bus.MEM_READDATA;
          valid_d[miss_idx_q] = 1'b0;
          state_d             = ALLOCATE;
        end
      end

      ALLOCATE: begin
        bus.BUSYWAIT        = 1'b1;
        valid_d[miss_idx_q] = 1'b1;
        dirty_d[miss_idx_q] = 1'b0;
        state_d             = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      dirty_q    <= '0;
      miss_idx_q <= '0;
      miss_tag_q <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      dirty_q    <= dirty_d;
      miss_idx_q <= miss_idx_d;
      miss_tag_q <= miss_tag_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (line_we) begin
      data_q[line_idx] <= line_data;
      tag_q[line_idx]  <= line_tag;
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  // Both counters wrap naturally at 32 bits.
  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (state_q == IDLE && req && hit) begin
      hit_count_d = hit_count_q + 32'd1;
    end
    if (state_q == IDLE && state_d != IDLE) begin
      miss_count_d = miss_count_q + 32'd1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      hit_count_q  <= 32'h0;
      miss_count_q <= 32'h0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign HIT_COUNT  = hit_count_q;
  assign MISS_COUNT = miss_count_q;
`endif

endmodule
